// File: rtl/steer_pkg.sv
// -----------------------------------------------------------------------------
// steer_pkg
//
// Shared types and constants for the rider-detect / steer-enable controller.
//
// Contents:
//    state_t          - controller state (IDLE / WAIT / STEER, 3 is illegal)
//    MIN_RIDER_WT_DEF - default nominal minimum rider weight
//    WT_HYST_DEF      - default hysteresis around the minimum rider weight
//    FAST_TMR_BITS    - settle-timer width used when FAST_SIM is set
//    settle_bits()    - picks the settle-timer width from FAST_SIM / TMR_W
// -----------------------------------------------------------------------------
package steer_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WAIT  = 2'd1,
      STEER = 2'd2
   } state_t;

   localparam int MIN_RIDER_WT_DEF = 'h200;
   localparam int WT_HYST_DEF      = 'h040;
   localparam int FAST_TMR_BITS    = 15;

   // Simulation builds shorten the settle time to keep runs tractable; the
   // normal width comes from the instantiating block.
   function automatic int settle_bits(input bit fast_sim, input int tmr_w);
      return fast_sim ? FAST_TMR_BITS : tmr_w;
   endfunction

endpackage

// File: rtl/steer_en_p_sm.sv
// -----------------------------------------------------------------------------
// steer_en_p_sm
//
// State machine and output registers of the steer-enable controller. All
// arithmetic, the settle timer and the off counter live in the parent; this
// block only sees the resulting condition flags.
//
// Ports:
//    clk           in   system clock
//    rst_n         in   asynchronous active-low reset
//    ld_vld        in   load sample strobe; decisions happen only when high
//    sum_lt_min    in   total load below the lower rider threshold
//    sum_gt_min    in   total load above the upper rider threshold
//    diff_gt_1_4   in   left/right imbalance above a quarter of the total
//    diff_gt_15_16 in   left/right imbalance above 15/16 of the total
//    tmr_full      in   settle timer has saturated
//    off_done      in   this light sample completes the rider-off debounce
//    clr_tmr       out  clear the settle timer on this edge
//    en_steer      out  steering enabled (registered, high iff in STEER)
//    rider_off     out  one-cycle pulse when the rider leaves (registered)
//    state         out  current state, for debug
// -----------------------------------------------------------------------------
module steer_en_p_sm
   import steer_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ld_vld,
   input  logic       sum_lt_min,
   input  logic       sum_gt_min,
   input  logic       diff_gt_1_4,
   input  logic       diff_gt_15_16,
   input  logic       tmr_full,
   input  logic       off_done,
   output logic       clr_tmr,
   output logic       en_steer,
   output logic       rider_off,
   output logic [1:0] state
);

   state_t cur;
   logic   light_hold;

   assign state = cur;

   // A light sample that has not yet completed the debounce freezes the
   // decision: no state change and no timer clear, so the timer keeps counting.
   assign light_hold = sum_lt_min && !off_done;

   // The timer clear must act on the same edge as the decision it belongs to,
   // so it is decoded from the current state and flags rather than registered.
   // It covers entry into WAIT from either IDLE or STEER, and an imbalanced
   // sample while waiting to settle.
   assign clr_tmr = ld_vld &&
                    (((cur == IDLE)  && sum_gt_min) ||
                     ((cur == WAIT)  && !off_done && !light_hold && diff_gt_1_4) ||
                     ((cur == STEER) && !off_done && !light_hold && diff_gt_15_16));

   // Single registered state machine. Within each state the checks are in
   // priority order, so a completed rider-off debounce always beats an
   // imbalance condition seen on the same sample. en_steer is written on every
   // transition into or out of STEER so it always mirrors the state, and
   // rider_off defaults low so it can only ever be a single-cycle pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= IDLE;
         en_steer  <= 1'b0;
         rider_off <= 1'b0;
      end else begin
         rider_off <= 1'b0;
         case (cur)
            IDLE: begin
               if (ld_vld && sum_gt_min) begin
                  cur <= WAIT;
               end
            end
            WAIT: begin
               if (ld_vld) begin
                  if (off_done) begin
                     cur       <= IDLE;
                     rider_off <= 1'b1;
                  end else if (light_hold) begin
                     cur <= WAIT;
                  end else if (diff_gt_1_4) begin
                     cur <= WAIT;
                  end else if (tmr_full) begin
                     cur      <= STEER;
                     en_steer <= 1'b1;
                  end
               end
            end
            STEER: begin
               if (ld_vld) begin
                  if (off_done) begin
                     cur       <= IDLE;
                     en_steer  <= 1'b0;
                     rider_off <= 1'b1;
                  end else if (light_hold) begin
                     cur <= STEER;
                  end else if (diff_gt_15_16) begin
                     cur      <= WAIT;
                     en_steer <= 1'b0;
                  end
               end
            end
            default: begin
               cur       <= IDLE;
               en_steer  <= 1'b0;
               rider_off <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: rtl/steer_en_p.sv
// -----------------------------------------------------------------------------
// steer_en_p
//
// Parametrised rider-detect / steer-enable controller for the load-cell front
// end. Combines left and right load samples into total-weight and imbalance
// flags, runs the settle timer and the rider-off debounce counter, and hands
// the flags to the state machine in steer_en_p_sm.
//
// Parameters:
//    LD_W         load-cell sample width (unsigned)
//    MIN_RIDER_WT nominal minimum rider weight
//    WT_HYST      hysteresis around MIN_RIDER_WT
//    TMR_W        settle-timer width for normal operation
//    FAST_SIM     1 = short settle timer for simulation
//    OFF_SMPLS    consecutive light samples that declare the rider off (>= 1)
//
// Ports:
//    clk       in   system clock
//    rst_n     in   asynchronous active-low reset
//    lft_ld    in   left load cell sample
//    rght_ld   in   right load cell sample
//    ld_vld    in   sample strobe; loads are evaluated only when high
//    en_steer  out  steering enabled (registered)
//    rider_off out  single-cycle pulse when the rider leaves (registered)
//    state     out  FSM state, for debug
// -----------------------------------------------------------------------------
module steer_en_p
   import steer_pkg::*;
#(
   parameter int LD_W         = 12,
   parameter int MIN_RIDER_WT = MIN_RIDER_WT_DEF,
   parameter int WT_HYST      = WT_HYST_DEF,
   parameter int TMR_W        = 26,
   parameter bit FAST_SIM     = 1'b0,
   parameter int OFF_SMPLS    = 4
)(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [LD_W-1:0] lft_ld,
   input  logic [LD_W-1:0] rght_ld,
   input  logic            ld_vld,
   output logic            en_steer,
   output logic            rider_off,
   output logic [1:0]      state
);

   localparam int TB = settle_bits(FAST_SIM, TMR_W);
   localparam int SW = LD_W + 1;
   localparam int CW = $clog2(OFF_SMPLS + 1);

   // Thresholds carry one guard bit beyond the sum so that a large
   // MIN_RIDER_WT + WT_HYST cannot wrap into a small value.
   localparam logic [SW:0]   LO_THR   = (SW+1)'(MIN_RIDER_WT - WT_HYST);
   localparam logic [SW:0]   HI_THR   = (SW+1)'(MIN_RIDER_WT + WT_HYST);
   localparam logic [CW-1:0] OFF_MAX  = CW'(OFF_SMPLS);
   localparam logic [CW-1:0] OFF_LAST = CW'(OFF_SMPLS - 1);

   logic [SW-1:0]        sum;
   logic signed [SW-1:0] diff;
   logic [SW-1:0]        abs_diff;
   logic                 sum_lt_min;
   logic                 sum_gt_min;
   logic                 diff_gt_1_4;
   logic                 diff_gt_15_16;

   logic [TB-1:0]        tmr;
   logic                 tmr_full;
   logic                 clr_tmr;

   logic [CW-1:0]        off_cnt;
   logic                 off_done;
   logic                 to_idle;

   // The sum and difference are both one bit wider than a sample so that a
   // full-scale left/right split neither overflows the sum nor wraps the
   // signed difference before its magnitude is taken.
   assign sum      = {1'b0, lft_ld} + {1'b0, rght_ld};
   assign diff     = $signed({1'b0, lft_ld}) - $signed({1'b0, rght_ld});
   assign abs_diff = diff[SW-1] ? $unsigned(-diff) : $unsigned(diff);

   assign sum_lt_min    = {1'b0, sum} < LO_THR;
   assign sum_gt_min    = {1'b0, sum} > HI_THR;
   assign diff_gt_1_4   = abs_diff > (sum >> 2);
   assign diff_gt_15_16 = abs_diff > (sum - (sum >> 4));

   assign tmr_full = &tmr;

   // The debounce completes on the sample that would bring the count to
   // OFF_SMPLS, so the state machine can react on that same edge.
   assign off_done = sum_lt_min && (off_cnt >= OFF_LAST);

   // Leaving WAIT/STEER for IDLE (rider off, or recovery from the illegal
   // encoding) restarts the debounce from zero.
   assign to_idle = (state != IDLE) &&
                    ((state == 2'b11) || (ld_vld && off_done));

   // Settle timer: runs every clock while waiting to settle and holds at
   // all-ones once full, so a transition deferred by a missing strobe still
   // sees a full timer on the next valid sample.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tmr <= '0;
      end else if (clr_tmr) begin
         tmr <= '0;
      end else if ((state == WAIT) && !tmr_full) begin
         tmr <= tmr + TB'(1);
      end
   end

   // Rider-off debounce: counts consecutive accepted light samples, saturating
   // at OFF_SMPLS; any accepted non-light sample restarts the run.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         off_cnt <= '0;
      end else if (to_idle) begin
         off_cnt <= '0;
      end else if (ld_vld) begin
         if (!sum_lt_min) begin
            off_cnt <= '0;
         end else if (off_cnt < OFF_MAX) begin
            off_cnt <= off_cnt + CW'(1);
         end
      end
   end

   steer_en_p_sm u_sm (
      .clk           (clk),
      .rst_n         (rst_n),
      .ld_vld        (ld_vld),
      .sum_lt_min    (sum_lt_min),
      .sum_gt_min    (sum_gt_min),
      .diff_gt_1_4   (diff_gt_1_4),
      .diff_gt_15_16 (diff_gt_15_16),
      .tmr_full      (tmr_full),
      .off_done      (off_done),
      .clr_tmr       (clr_tmr),
      .en_steer      (en_steer),
      .rider_off     (rider_off),
      .state         (state)
   );

endmodule

// File: tb/tb_steer_en_p.sv
// -----------------------------------------------------------------------------
// tb_steer_en_p
//
// Self-checking bench for steer_en_p (LD_W=12, FAST_SIM=1, OFF_SMPLS=4).
// A behavioural model tracks the rider state from the load rules, using the
// number of clocks elapsed since the last timer clear instead of a counter,
// and is compared against the DUT on every falling edge. Directed sequences
// pin the model and DUT to hand-computed values; a randomized phase exercises
// mount / imbalance / step-off mixes.
// -----------------------------------------------------------------------------
module tb_steer_en_p;

   localparam int MIN_WT   = 'h200;
   localparam int HYST     = 'h040;
   localparam int OFF_N    = 4;
   localparam int TMR_MAX  = (1 << 15) - 1;

   logic        clk     = 1'b0;
   logic        rst_n   = 1'b1;
   logic        ld_vld  = 1'b0;
   logic [11:0] lft_ld  = '0;
   logic [11:0] rght_ld = '0;
   logic        en_steer;
   logic        rider_off;
   logic [1:0]  state;

   int total   = 0;
   int bad     = 0;
   int steer_k = -1;
   bit chk_en  = 1'b0;

   // Behavioural model state
   int     m_st    = 0;
   int     m_run   = 0;
   bit     m_off   = 1'b0;
   longint cyc     = 0;
   longint clr_cyc = 0;

   steer_en_p #(
      .LD_W         (12),
      .MIN_RIDER_WT ('h200),
      .WT_HYST      ('h040),
      .TMR_W        (26),
      .FAST_SIM     (1'b1),
      .OFF_SMPLS    (4)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .lft_ld    (lft_ld),
      .rght_ld   (rght_ld),
      .ld_vld    (ld_vld),
      .en_steer  (en_steer),
      .rider_off (rider_off),
      .state     (state)
   );

   always #5 clk = ~clk;

   // Reference model: applies the rider rules to each accepted sample. The
   // settle timer is represented by the clock index of its last clear; it is
   // full once at least 2^15-1 clocks have passed since then.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_st  = 0;
         m_run = 0;
         m_off = 1'b0;
      end else begin
         int s;
         int d;
         bit light;
         bit heavy;
         bit done;
         bit full;
         cyc++;
         m_off = 1'b0;
         if (ld_vld) begin
            s     = int'(lft_ld) + int'(rght_ld);
            d     = (lft_ld > rght_ld) ? int'(lft_ld) - int'(rght_ld)
                                       : int'(rght_ld) - int'(lft_ld);
            light = s < (MIN_WT - HYST);
            heavy = s > (MIN_WT + HYST);
            done  = light && (m_run + 1 >= OFF_N);
            full  = (cyc - 1 - clr_cyc) >= TMR_MAX;
            case (m_st)
               0: begin
                  if (heavy) begin
                     m_st    = 1;
                     clr_cyc = cyc;
                  end
               end
               1: begin
                  if (done) begin
                     m_st  = 0;
                     m_off = 1'b1;
                  end else if (!light) begin
                     if (d > s / 4) clr_cyc = cyc;
                     else if (full) m_st = 2;
                  end
               end
               default: begin
                  if (done) begin
                     m_st  = 0;
                     m_off = 1'b1;
                  end else if (!light && (d > s - s / 16)) begin
                     m_st    = 1;
                     clr_cyc = cyc;
                  end
               end
            endcase
            if (m_off)      m_run = 0;
            else if (light) m_run = (m_run < OFF_N) ? m_run + 1 : OFF_N;
            else            m_run = 0;
         end
      end
   end

   // Every-cycle comparison of the registered outputs against the model,
   // sampled on the falling edge, away from the active edge.
   always @(negedge clk) begin
      if (chk_en) begin
         logic [3:0] want;
         want = {2'(m_st), (m_st == 2), m_off};
         total++;
         if ({state, en_steer, rider_off} !== want) begin
            bad++;
            $display("[TB] FAIL cycle_check t=%0t got state=%0d en=%0b off=%0b want state=%0d en=%0b off=%0b",
                     $time, state, en_steer, rider_off, want[3:2], want[1], want[0]);
         end
      end
   end

   // Watchdog: the bench must never hang.
   initial begin
      #5_000_000;
      $display("[TB] FAIL watchdog expired at t=%0t", $time);
      $display("test done: total=%0d bad=%0d", total, bad + 1);
      $fatal(1, "[TB] watchdog");
   end

   // Drives one sample pattern for n clocks; returns 1 time unit after the
   // last rising edge so outputs reflect that edge.
   task automatic applyStimulus(input logic [11:0] l, input logic [11:0] r,
                                input logic v, input int n);
      repeat (n) begin
         lft_ld  = l;
         rght_ld = r;
         ld_vld  = v;
         @(posedge clk);
         #1;
      end
   endtask

   // Compares both the DUT and the model against hand-computed values.
   task automatic checkOutput(input string name, input int st, input bit en,
                              input bit off);
      total++;
      if (state !== 2'(st) || en_steer !== en || rider_off !== off) begin
         bad++;
         $display("[TB] FAIL %s dut state=%0d en=%0b off=%0b required state=%0d en=%0b off=%0b",
                  name, state, en_steer, rider_off, st, en, off);
      end
      total++;
      if (m_st != st || m_off != off) begin
         bad++;
         $display("[TB] FAIL %s_model model state=%0d off=%0b required state=%0d off=%0b",
                  name, m_st, m_off, st, off);
      end
   endtask

   task automatic doReset();
      rst_n  = 1'b0;
      ld_vld = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   // Randomized mix of sample classes, each held for a short burst so that
   // debounce runs and mounts actually occur.
   task automatic randomPhase(input int n);
      int          left_cycles;
      int          cls;
      logic [11:0] l;
      logic [11:0] r;
      left_cycles = 0;
      cls         = 0;
      for (int i = 0; i < n; i++) begin
         if (left_cycles == 0) begin
            cls         = int'($urandom_range(0, 4));
            left_cycles = int'($urandom_range(1, 8));
         end
         left_cycles--;
         case (cls)
            0: begin
               l = 12'($urandom_range(0, 'hDF));
               r = 12'($urandom_range(0, 'hDF));
            end
            1: begin
               l = 12'($urandom_range('h120, 'h400));
               r = l;
            end
            2: begin
               l = 12'($urandom_range('h200, 'hFFF));
               r = 12'($urandom_range(0, 'h100));
            end
            3: begin
               l = 12'($urandom);
               r = 12'($urandom);
            end
            default: begin
               l = 12'($urandom_range('hD0, 'h130));
               r = 12'($urandom_range('hD0, 'h130));
            end
         endcase
         if ($urandom_range(0, 1) == 0) begin
            logic [11:0] t;
            t = l;
            l = r;
            r = t;
         end
         applyStimulus(l, r, ($urandom_range(0, 3) != 0), 1);
      end
   endtask

   initial begin
      $display("[TB] start");
      #2;
      rst_n = 1'b0;
      #1;
      chk_en = 1'b1;
      doReset();
      checkOutput("reset_state", 0, 1'b0, 1'b0);

      // Randomized phase, then a clean restart for the directed sequences.
      randomPhase(3000);
      doReset();
      checkOutput("reset_after_random", 0, 1'b0, 1'b0);

      // Balanced mount: WAIT on the first sample, STEER 2^15 clocks later.
      applyStimulus(12'h180, 12'h180, 1'b1, 1);
      checkOutput("mount_wait", 1, 1'b0, 1'b0);
      applyStimulus(12'h180, 12'h180, 1'b1, 32767);
      checkOutput("mount_before_full", 1, 1'b0, 1'b0);
      applyStimulus(12'h180, 12'h180, 1'b1, 1);
      checkOutput("mount_steer", 2, 1'b1, 1'b0);

      // Step-off debounce interrupted by a heavy sample: stays in STEER.
      applyStimulus(12'h080, 12'h080, 1'b1, 3);
      checkOutput("light3_hold", 2, 1'b1, 1'b0);
      applyStimulus(12'h180, 12'h180, 1'b1, 1);
      checkOutput("light_run_broken", 2, 1'b1, 1'b0);
      applyStimulus(12'h080, 12'h080, 1'b1, 3);
      checkOutput("light3_again", 2, 1'b1, 1'b0);

      // Heavy imbalance in STEER: back to WAIT on the same edge, no rider_off.
      applyStimulus(12'h300, 12'h000, 1'b1, 1);
      checkOutput("heavy_imbalance", 1, 1'b0, 1'b0);

      // Let the timer run part way, then lopsided samples must restart it.
      applyStimulus(12'h180, 12'h180, 1'b0, 10000);
      checkOutput("wait_no_strobe", 1, 1'b0, 1'b0);
      applyStimulus(12'h200, 12'h080, 1'b1, 10);
      checkOutput("lopsided_wait", 1, 1'b0, 1'b0);

      // Sparse strobes: first balanced sample 3 clocks after the last clear,
      // then every 8th clock. The timer fills after 2^15 clocks and must hold
      // until strobe index 4096 (clock 32771 after the clear).
      applyStimulus(12'h180, 12'h180, 1'b0, 2);
      for (int k = 0; k < 4200; k++) begin
         applyStimulus(12'h180, 12'h180, 1'b1, 1);
         if (en_steer) begin
            steer_k = k;
            break;
         end
         applyStimulus(12'h180, 12'h180, 1'b0, 7);
      end
      total++;
      if (steer_k != 4096) begin
         bad++;
         $display("[TB] FAIL sparse_steer_strobe got %0d required 4096", steer_k);
      end
      checkOutput("sparse_steer", 2, 1'b1, 1'b0);

      // Full step-off: rider_off and IDLE on the fourth light sample.
      applyStimulus(12'h080, 12'h080, 1'b1, 3);
      checkOutput("stepoff_3", 2, 1'b1, 1'b0);
      applyStimulus(12'h080, 12'h080, 1'b1, 1);
      checkOutput("stepoff_4", 0, 1'b0, 1'b1);
      applyStimulus(12'h080, 12'h080, 1'b1, 1);
      checkOutput("rider_off_single", 0, 1'b0, 1'b0);

      // Asynchronous reset asserted mid-cycle while in WAIT.
      applyStimulus(12'h180, 12'h180, 1'b1, 1);
      checkOutput("remount_wait", 1, 1'b0, 1'b0);
      applyStimulus(12'hFFF, 12'h000, 1'b1, 5);
      checkOutput("fullscale_wait", 1, 1'b0, 1'b0);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_reset", 0, 1'b0, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      applyStimulus(12'h100, 12'h100, 1'b1, 1);
      checkOutput("post_reset_idle", 0, 1'b0, 1'b0);

      @(negedge clk);
      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/steer_en_p.md
# steer_en_p

Parametrised rider-detect / steer-enable controller for the platform's load-cell front end. It replaces the fixed-width 12-bit steer enable with configurable load width, timer length and thresholds. The FSM lives inside the block. Load samples are qualified by a valid strobe, and rider-off is debounced across several samples. It sits between the load-cell A2D interface and the steering/balance control, which gates steering on `en_steer` and reacts to the `rider_off` pulse.

## Interface
- `LD_W`, 12: load-cell sample width (unsigned).
- `MIN_RIDER_WT`, 'h200: nominal minimum rider weight (`LD_W`+1 bits).
- `WT_HYST`, 'h040: hysteresis around `MIN_RIDER_WT`.
- `TMR_W`, 26: settle-timer width for normal operation.
- `FAST_SIM`, 0: when 1, the settle timer uses 15 bits.
- `OFF_SMPLS`, 4: consecutive light samples needed to declare the rider off (≥1).
- `clk` in 1: system clock.
- `rst_n` in 1: asynchronous active-low reset.
- `lft_ld` in `LD_W`: left load cell.
- `rght_ld` in `LD_W`: right load cell.
- `ld_vld` in 1: sample strobe; loads are evaluated only when high.
- `en_steer` out 1: steering enabled (registered).
- `rider_off` out 1: single-cycle pulse when the rider leaves (registered).
- `state` out 2: FSM state, for debug.

## Operation
- `sum` = `lft_ld` + `rght_ld`, `LD_W`+1 bits, no overflow.
- `abs_diff` = |`lft_ld` − `rght_ld`|, computed `LD_W`+1 signed, then magnitude taken. Full-scale differences must not wrap.
- `sum_lt_min` = `sum` < `MIN_RIDER_WT` − `WT_HYST`.
- `sum_gt_min` = `sum` > `MIN_RIDER_WT` + `WT_HYST`.
- `diff_gt_1_4` = `abs_diff` > (`sum`>>2).
- `diff_gt_15_16` = `abs_diff` > `sum` − (`sum`>>4).
- Settle timer:
  - counts every clk while in WAIT.
  - cleared on entry to WAIT and on any accepted sample with `diff_gt_1_4`.
  - `tmr_full` = all ones in the low `TB` bits, where `TB` = `FAST_SIM` ? 15 : `TMR_W`.
- Off counter: increments on each accepted sample with `sum_lt_min`, up to `OFF_SMPLS`. Clears on any accepted sample without `sum_lt_min`, and on entry to IDLE.
- States: IDLE=0, WAIT=1, STEER=2. Encoding 3 is illegal and recovers to IDLE.
- Transitions are evaluated only when `ld_vld`=1. Priority is top-down within each state.
  - IDLE:
    - `sum_gt_min` → WAIT.
  - WAIT:
    - off count reaches `OFF_SMPLS` → IDLE, pulse `rider_off`.
    - `diff_gt_1_4` → stay in WAIT, clear timer.
    - `tmr_full` → STEER.
  - STEER:
    - off count reaches `OFF_SMPLS` → IDLE, pulse `rider_off`, deassert `en_steer`.
    - `diff_gt_15_16` → WAIT, clear timer, deassert `en_steer`.
- When off count reaches `OFF_SMPLS` and the diff condition hold together, rider-off wins.
- A light sample in WAIT/STEER that has not yet reached the count keeps the current state. The timer keeps counting.

## Timing
- Reset values: `state`=IDLE, `en_steer`=0, `rider_off`=0, timer=0, off counter=0. Reset takes effect immediately (asynchronous), including mid-STEER.
- Zero-cycle decision latency: state, `en_steer` and `rider_off` update on the same rising edge that accepts the deciding sample.
- `rider_off` is high for exactly one clk and never in consecutive cycles.
- `en_steer` is high iff `state`==STEER.
- When `tmr_full` holds but `ld_vld` is low, the transition waits for the next valid sample. The timer saturates at all-ones meanwhile (no wrap).
- `OFF_SMPLS`=1 reproduces single-sample rider-off behaviour.

## Structure
- Package `steer_pkg`:
  - `state_t` enum (IDLE/WAIT/STEER).
  - default constants `MIN_RIDER_WT_DEF`, `WT_HYST_DEF`.
  - `FAST_TMR_BITS`=15.
- Sub-module `steer_en_p_sm`: FSM and output registers only. Inputs are the condition flags plus `ld_vld`, `tmr_full` and `off_done`. Outputs are `clr_tmr`, `en_steer`, `rider_off` and `state`.
- The top level holds the arithmetic, the timer and the off counter.

## Test plan
All scenarios use `LD_W`=12, `FAST_SIM`=1, `OFF_SMPLS`=4.
- **Reset:** assert `rst_n`=0 mid-clock with any inputs → `en_steer`=0, `rider_off`=0, `state`=0 immediately.
- **Balanced mount:** `lft`=`rght`=0x180 with `ld_vld` every clk → WAIT on the first sample. `en_steer` rises once the timer saturates (2^15−1 clks) at the next valid sample.
- **Lopsided in WAIT:** `lft`=0x200, `rght`=0x080 (diff 0x180 > 0x0A0) → timer cleared every sample, `en_steer` stays 0. Return to balanced → `en_steer` after a full timer period.
- **Heavy imbalance in STEER:** `lft`=0x300, `rght`=0x000 (0x300 > 0x2D0) → WAIT and `en_steer`=0 on the same edge, no `rider_off`.
- **Step-off debounce:** in STEER, `sum`=0x100 for 3 samples then 0x300 → stays in STEER. `sum`=0x100 for 4 samples → one-cycle `rider_off`, IDLE, `en_steer`=0 on the fourth sample.
- **Sparse valid:** `ld_vld` every 8th clk during balanced mount → transitions only on strobed edges. Timer saturates rather than wrapping.
